// File: rtl/aq_fifo_pkg.sv
// Shared definitions for the sample-FIFO read-side drain stage.
package aq_fifo_pkg;
   localparam int LEN_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;
endpackage

// File: rtl/aq_stream_skid.sv
// Two-entry register slice; entry 0 drives the outputs directly.
module aq_stream_skid #(
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);
   logic             vld0, vld1;
   logic [WIDTH-1:0] d0, d1;
   logic             push, pop;

   assign pop       = vld0 & out_ready;
   // vld1 implies vld0, so the slice is full exactly when vld1 is set
   assign in_ready  = ~vld1 | pop;
   assign push      = in_valid & in_ready;
   assign out_valid = vld0;
   assign out_data  = d0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld0 <= 1'b0;
         vld1 <= 1'b0;
         d0   <= '0;
         d1   <= '0;
      end else begin
         case ({push, pop})
            2'b11: begin
               if (vld1) begin
                  d0 <= d1;
                  d1 <= in_data;
               end else begin
                  d0 <= in_data;
               end
            end
            2'b10: begin
               if (vld0) begin
                  d1   <= in_data;
                  vld1 <= 1'b1;
               end else begin
                  d0   <= in_data;
                  vld0 <= 1'b1;
               end
            end
            2'b01: begin
               if (vld1) d0 <= d1;
               vld0 <= vld1;
               vld1 <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/aq_fifo_stream_out.sv
// Drains a show-ahead FIFO into an AXI4-Stream master, cut into packets of PKT_LEN beats.
module aq_fifo_stream_out
   import aq_fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = 64,
   parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  ENABLE,
   input  logic [LEN_WIDTH-1:0]  PKT_LEN,
   output logic                  FIFO_RD_ENA,
   input  logic [FIFO_WIDTH-1:0] FIFO_RD_DATA,
   input  logic                  FIFO_RD_EMPTY,
   output logic                  M_TVALID,
   input  logic                  M_TREADY,
   output logic [FIFO_WIDTH-1:0] M_TDATA,
   output logic                  M_TLAST,
   output logic                  BUSY,
   output logic [CNT_WIDTH-1:0]  PKT_COUNT
);
   localparam logic [LEN_WIDTH:0]   LEN_ONE = (LEN_WIDTH+1)'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t               state, state_nxt;
   logic [LEN_WIDTH:0]   beats_left, beats_left_nxt;
   logic                 run, pop, tag_last, last_hs;
   logic                 skid_ready, skid_valid;
   logic [FIFO_WIDTH:0]  skid_out;

   assign run         = (state == STREAM) && (beats_left != '0);
   assign pop         = run & ~FIFO_RD_EMPTY & skid_ready;
   assign tag_last    = (beats_left == LEN_ONE);
   assign FIFO_RD_ENA = pop;

   aq_stream_skid #(.WIDTH(FIFO_WIDTH + 1)) u_skid (
      .clk       (CLK),
      .rst_n     (RST_N),
      .in_valid  (pop),
      .in_ready  (skid_ready),
      .in_data   ({tag_last, FIFO_RD_DATA}),
      .out_valid (skid_valid),
      .out_ready (M_TREADY),
      .out_data  (skid_out)
   );

   assign M_TVALID = skid_valid;
   assign M_TDATA  = skid_out[FIFO_WIDTH-1:0];
   // mask the tag so a stale entry can never show TLAST without TVALID
   assign M_TLAST  = skid_valid & skid_out[FIFO_WIDTH];
   assign BUSY     = (state != IDLE);
   assign last_hs  = M_TVALID & M_TREADY & M_TLAST;

   always_comb begin
      state_nxt      = state;
      beats_left_nxt = beats_left;
      case (state)
         IDLE: begin
            if (ENABLE) begin
               state_nxt      = STREAM;
               beats_left_nxt = (PKT_LEN == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, PKT_LEN};
            end
         end
         STREAM: begin
            if (pop) beats_left_nxt = beats_left - LEN_ONE;
            if (pop && tag_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (last_hs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         beats_left <= '0;
         PKT_COUNT  <= '0;
      end else begin
         state      <= state_nxt;
         beats_left <= beats_left_nxt;
         if (last_hs) PKT_COUNT <= PKT_COUNT + CNT_ONE;
      end
   end
endmodule

// File: tb/tb_aq_fifo_stream_out.sv
// Directed bench for aq_fifo_stream_out: table of packet scenarios plus enable-drop and mid-packet reset.
module tb_aq_fifo_stream_out;
   localparam int FW = 64;
   localparam int LW = 4;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          enable = 1'b0;
   logic [LW-1:0] pkt_len = '0;
   logic          fifo_rd_ena;
   logic [FW-1:0] fifo_rd_data;
   logic          fifo_rd_empty;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic [FW-1:0] m_tdata;
   logic          m_tlast;
   logic          busy;
   logic [CW-1:0] pkt_count;

   aq_fifo_stream_out #(.FIFO_WIDTH(FW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
      .CLK           (clk),
      .RST_N         (rst_n),
      .ENABLE        (enable),
      .PKT_LEN       (pkt_len),
      .FIFO_RD_ENA   (fifo_rd_ena),
      .FIFO_RD_DATA  (fifo_rd_data),
      .FIFO_RD_EMPTY (fifo_rd_empty),
      .M_TVALID      (m_tvalid),
      .M_TREADY      (m_tready),
      .M_TDATA       (m_tdata),
      .M_TLAST       (m_tlast),
      .BUSY          (busy),
      .PKT_COUNT     (pkt_count)
   );

   always #5 clk = ~clk;

   // FIFO model: fixed word contents, wr_ptr releases words, pops advance rd_ptr
   logic [FW-1:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_rd_data  = mem[rd_ptr[7:0]];
   assign fifo_rd_empty = (rd_ptr == wr_ptr);
   always @(posedge clk) if (fifo_rd_ena) rd_ptr <= rd_ptr + 1;

   typedef struct {
      logic [LW-1:0] len;
      int            n1;
      bit            tog;
      int            gap_cyc;
      int            n2;
      int            beats;
      int            pkts;
      int            idle;
      int            min_vgap;
   } tv_t;
   tv_t tv [5];

   int errors = 0, checks = 0;
   int n, exp_start, exp_len, cur_beats, idle_cnt, vgap_cnt, start_rd;
   bit mon_on = 1'b0;
   bit prev_stall;
   logic [FW-1:0] prev_data;
   logic prev_last;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic mon_clear(input int len_eff, input int beats);
      n = 0; exp_start = rd_ptr; start_rd = rd_ptr; exp_len = len_eff; cur_beats = beats;
      idle_cnt = 0; vgap_cnt = 0; prev_stall = 1'b0; mon_on = 1'b1;
   endtask

   // one clock: sample/check at negedge, return at posedge+1 ready for new inputs
   task automatic cyc();
      @(negedge clk);
      if (mon_on) begin
         if (prev_stall) begin
            chk("hold_valid", 64'(m_tvalid), 64'd1);
            chk("hold_data", m_tdata, prev_data);
            chk("hold_last", 64'(m_tlast), 64'(prev_last));
         end
         if (n > 0 && n < cur_beats) begin
            if (!busy) idle_cnt++;
            if (!m_tvalid) vgap_cnt++;
         end
         if (m_tvalid && m_tready) begin
            chk("beat_data", m_tdata, mem[(exp_start + n) % 256]);
            chk("beat_last", 64'(m_tlast), 64'(((n + 1) % exp_len) == 0));
            n++;
         end
         prev_stall = m_tvalid & ~m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      mon_on = 1'b0; enable = 1'b0; m_tready = 1'b1;
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   initial begin
      for (int k = 0; k < 256; k++) mem[k] = 64'hA5A5_0000_0000_0000 | 64'(k * 3 + 1);
      tv[0] = '{4'd4, 8,  1'b0, -1, 0, 8,  2, 1, 0};
      tv[1] = '{4'd4, 8,  1'b1, -1, 0, 8,  2, 1, 0};
      tv[2] = '{4'd6, 3,  1'b0, 23, 3, 6,  1, 0, 15};
      tv[3] = '{4'd0, 16, 1'b0, -1, 0, 16, 1, 0, 0};
      tv[4] = '{4'd1, 3,  1'b0, -1, 0, 3,  3, 2, 0};

      #1 rst_n = 1'b0;
      #2;
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_tdata", m_tdata, 64'd0);
      chk("rst_tlast", 64'(m_tlast), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_count", 64'(pkt_count), 64'd0);
      chk("rst_rdena", 64'(fifo_rd_ena), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         do_reset();
         pkt_len = tv[i].len;
         mon_clear((tv[i].len == '0) ? 16 : int'(tv[i].len), tv[i].beats);
         wr_ptr = wr_ptr + tv[i].n1;
         enable = 1'b1;
         for (int c = 0; c < 400 && n < tv[i].beats; c++) begin
            if (tv[i].tog) m_tready = ~m_tready;
            if (c == tv[i].gap_cyc) wr_ptr = wr_ptr + tv[i].n2;
            cyc();
         end
         chk("case_beats", 64'(n), 64'(tv[i].beats));
         m_tready = 1'b1;
         for (int c = 0; c < 6; c++) cyc();
         chk("case_no_extra", 64'(n), 64'(tv[i].beats));
         chk("case_pkts", 64'(pkt_count), 64'(tv[i].pkts));
         chk("case_idle", 64'(idle_cnt), 64'(tv[i].idle));
         if (tv[i].min_vgap > 0) begin
            checks++;
            if (vgap_cnt < tv[i].min_vgap) begin
               errors++;
               $display("FAIL case_vgap: got %0d low cycles, required at least %0d", vgap_cnt, tv[i].min_vgap);
            end
         end
      end

      // ENABLE dropped after beat 1 of a 5-beat packet
      do_reset();
      pkt_len = 4'd5;
      mon_clear(5, 5);
      wr_ptr = wr_ptr + 12;
      enable = 1'b1;
      for (int c = 0; c < 60 && n < 2; c++) cyc();
      enable = 1'b0;
      for (int c = 0; c < 60 && n < 5; c++) cyc();
      for (int c = 0; c < 10; c++) cyc();
      chk("endrop_beats", 64'(n), 64'd5);
      chk("endrop_pkts", 64'(pkt_count), 64'd1);
      chk("endrop_busy", 64'(busy), 64'd0);
      chk("endrop_pops", 64'(rd_ptr - start_rd), 64'd5);

      // asynchronous reset in the middle of a packet
      do_reset();
      pkt_len = 4'd4;
      mon_clear(4, 4);
      wr_ptr = wr_ptr + 10;
      enable = 1'b1;
      for (int c = 0; c < 60 && n < 2; c++) cyc();
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("mid_rst_tdata", m_tdata, 64'd0);
      chk("mid_rst_tlast", 64'(m_tlast), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_rdena", 64'(fifo_rd_ena), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      mon_clear(4, 4);
      cyc();
      enable = 1'b0;
      for (int c = 0; c < 60 && n < 4; c++) cyc();
      for (int c = 0; c < 8; c++) cyc();
      chk("post_rst_beats", 64'(n), 64'd4);
      chk("post_rst_pkts", 64'(pkt_count), 64'd1);
      chk("post_rst_busy", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
